// File: rtl/iot_mon_pkg.sv
// Shared constants and helpers for the IoT fleet monitor.
package iot_mon_pkg;

  // Counter overflow behaviour selectors.
  localparam int WRAP = 0;
  localparam int SAT  = 1;

  // Width of the fleet total: one counter plus enough headroom to sum every channel.
  function automatic int total_width(input int width, input int channels);
    return width + $clog2(channels);
  endfunction

endpackage

// File: rtl/iot_fleet_monitor_if.sv
// Control, threshold and read-back bundle of the fleet monitor.
interface iot_fleet_monitor_if #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
);
  import iot_mon_pkg::*;

  localparam int TW = total_width(WIDTH, CHANNELS);

  logic [CHANNELS-1:0] change;
  logic [CHANNELS-1:0] on_off;
  logic                clr_peak;
  logic                clr_err;
  logic [TW-1:0]       thresh;
  logic [3:0]          rd_sel;
  logic [WIDTH-1:0]    count_out;
  logic [WIDTH-1:0]    peak_out;
  logic [TW-1:0]       total_out;
  logic [CHANNELS-1:0] err;
  logic                alarm;

  // Host side: drives events and reads status.
  modport master (
    output change, on_off, clr_peak, clr_err, thresh, rd_sel,
    input  count_out, peak_out, total_out, err, alarm
  );

  // Monitor side.
  modport slave (
    input  change, on_off, clr_peak, clr_err, thresh, rd_sel,
    output count_out, peak_out, total_out, err, alarm
  );

endinterface

// File: rtl/iot_chan_counter.sv
// One device group: up/down counter with wrap or clamp, sticky error and peak tracker.
module iot_chan_counter
  import iot_mon_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int SATURATE = WRAP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             change,
  input  logic             on_off,
  input  logic             clr_peak,
  input  logic             clr_err,
  output logic [WIDTH-1:0] cnt,
  output logic [WIDTH-1:0] peak,
  output logic             err
);

  localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] CNT_MIN = '0;

  logic [WIDTH-1:0] cnt_reg, cnt_next;
  logic [WIDTH-1:0] peak_reg, peak_next;
  logic             err_reg, err_next;
  logic             blocked;

  // Next count, blocked-move detection, sticky error and peak follow-up.
  always_comb begin
    cnt_next = cnt_reg;
    blocked  = 1'b0;
    if (change) begin
      if (on_off) begin
        if (SATURATE == SAT && cnt_reg == CNT_MAX) blocked = 1'b1;
        else cnt_next = cnt_reg + WIDTH'(1);
      end else begin
        if (SATURATE == SAT && cnt_reg == CNT_MIN) blocked = 1'b1;
        else cnt_next = cnt_reg - WIDTH'(1);
      end
    end
    // A fresh error in the clearing cycle survives the clear.
    err_next = blocked | (err_reg & ~clr_err);
    // Peak is re-based on the post-update count so a clear never loses the new value.
    if (clr_peak || cnt_next > peak_reg) peak_next = cnt_next;
    else peak_next = peak_reg;
  end

  // Channel state registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg  <= '0;
      peak_reg <= '0;
      err_reg  <= 1'b0;
    end else begin
      cnt_reg  <= cnt_next;
      peak_reg <= peak_next;
      err_reg  <= err_next;
    end
  end

  assign cnt  = cnt_reg;
  assign peak = peak_reg;
  assign err  = err_reg;

endmodule

// File: rtl/iot_fleet_monitor.sv
// Fleet monitor top: per-channel counters, registered fleet total, hysteretic alarm, read mux.
module iot_fleet_monitor
  import iot_mon_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int SATURATE = WRAP,
  parameter int HYST     = 2
) (
  input logic               clk,
  input logic               rst,
  iot_fleet_monitor_if.slave bus
);

  localparam int TW = total_width(WIDTH, CHANNELS);
  localparam logic [TW-1:0] HYST_W = TW'(HYST);

  logic [WIDTH-1:0]    cnt_arr  [CHANNELS];
  logic [WIDTH-1:0]    peak_arr [CHANNELS];
  logic [CHANNELS-1:0] err_vec;
  logic [TW-1:0]       total_reg, total_next;
  logic                alarm_reg, alarm_next;
  logic [WIDTH-1:0]    count_mux, peak_mux;

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
      iot_chan_counter #(
        .WIDTH    (WIDTH),
        .SATURATE (SATURATE)
      ) u_chan (
        .clk      (clk),
        .rst      (rst),
        .change   (bus.change[gi]),
        .on_off   (bus.on_off[gi]),
        .clr_peak (bus.clr_peak),
        .clr_err  (bus.clr_err),
        .cnt      (cnt_arr[gi]),
        .peak     (peak_arr[gi]),
        .err      (err_vec[gi])
      );
    end
  endgenerate

  // Sum of the current channel counts; registered below, so it trails the counters by one cycle.
  always_comb begin
    total_next = '0;
    for (int i = 0; i < CHANNELS; i++) total_next = total_next + TW'(cnt_arr[i]);
  end

  // Alarm sets at or above threshold and releases only below threshold minus hysteresis
  // (or at an empty fleet when the threshold is smaller than the hysteresis).
  always_comb begin
    alarm_next = alarm_reg;
    if (total_reg >= bus.thresh) begin
      alarm_next = 1'b1;
    end else if (bus.thresh >= HYST_W) begin
      if (total_reg < bus.thresh - HYST_W) alarm_next = 1'b0;
    end else if (total_reg == '0) begin
      alarm_next = 1'b0;
    end
  end

  // Fleet total and alarm registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      total_reg <= '0;
      alarm_reg <= 1'b0;
    end else begin
      total_reg <= total_next;
      alarm_reg <= alarm_next;
    end
  end

  // Read-back mux; selects beyond the channel count read as zero.
  always_comb begin
    count_mux = '0;
    peak_mux  = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (bus.rd_sel == 4'(i)) begin
        count_mux = cnt_arr[i];
        peak_mux  = peak_arr[i];
      end
    end
  end

  assign bus.count_out = count_mux;
  assign bus.peak_out  = peak_mux;
  assign bus.total_out = total_reg;
  assign bus.err       = err_vec;
  assign bus.alarm     = alarm_reg;

endmodule

// File: tb/tb_iot_fleet_monitor.sv
// Self-checking bench: wrap and saturate monitors side by side against an integer fleet model.
module tb_iot_fleet_monitor;

  localparam int W    = 8;
  localparam int CH   = 4;
  localparam int HYST = 2;
  localparam int MAXV = 255;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] change, on_off;
  logic       clr_peak, clr_err;
  logic [9:0] thresh;
  logic [3:0] rd_sel;
  logic       started = 1'b0;

  int checks = 0;
  int errors = 0;

  // Model: index 0 = wrapping monitor, 1 = saturating monitor.
  int m_cnt  [2][CH];
  int m_peak [2][CH];
  int m_err  [2][CH];
  int m_total[2];
  int m_alarm[2];

  always #5 clk = ~clk;

  iot_fleet_monitor_if #(.WIDTH(W), .CHANNELS(CH)) bw ();
  iot_fleet_monitor_if #(.WIDTH(W), .CHANNELS(CH)) bs ();

  assign bw.change = change;   assign bs.change = change;
  assign bw.on_off = on_off;   assign bs.on_off = on_off;
  assign bw.clr_peak = clr_peak; assign bs.clr_peak = clr_peak;
  assign bw.clr_err = clr_err; assign bs.clr_err = clr_err;
  assign bw.thresh = thresh;   assign bs.thresh = thresh;
  assign bw.rd_sel = rd_sel;   assign bs.rd_sel = rd_sel;

  iot_fleet_monitor #(.WIDTH(W), .CHANNELS(CH), .SATURATE(0), .HYST(HYST)) dut_wrap (
    .clk (clk), .rst (rst), .bus (bw)
  );
  iot_fleet_monitor #(.WIDTH(W), .CHANNELS(CH), .SATURATE(1), .HYST(HYST)) dut_sat (
    .clk (clk), .rst (rst), .bus (bs)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      for (int c = 0; c < CH; c++) begin
        m_cnt[s][c] = 0; m_peak[s][c] = 0; m_err[s][c] = 0;
      end
      m_total[s] = 0;
      m_alarm[s] = 0;
    end
  endtask

  // One clock of fleet behaviour in plain integer arithmetic.
  task automatic model_step();
    for (int s = 0; s < 2; s++) begin
      int sum = 0;
      int th = int'(thresh);
      for (int c = 0; c < CH; c++) sum += m_cnt[s][c];
      if (m_total[s] >= th) m_alarm[s] = 1;
      else if (th >= HYST) begin
        if (m_total[s] < th - HYST) m_alarm[s] = 0;
      end else if (m_total[s] == 0) m_alarm[s] = 0;
      m_total[s] = sum;
      for (int c = 0; c < CH; c++) begin
        int nv = m_cnt[s][c];
        int new_err = 0;
        if (change[c]) begin
          nv = on_off[c] ? nv + 1 : nv - 1;
          if (nv < 0 || nv > MAXV) begin
            if (s == 1) begin new_err = 1; nv = m_cnt[s][c]; end
            else nv = (nv + MAXV + 1) % (MAXV + 1);
          end
        end
        m_cnt[s][c] = nv;
        if (new_err == 1) m_err[s][c] = 1;
        else if (clr_err) m_err[s][c] = 0;
        if (clr_peak || nv > m_peak[s][c]) m_peak[s][c] = nv;
      end
    end
  endtask

  task automatic compare_dut(input int s, input string tag, input logic [7:0] cnt_o,
                             input logic [7:0] peak_o, input logic [9:0] total_o,
                             input logic [3:0] err_o, input logic alarm_o);
    int idx = int'(rd_sel);
    int e_cnt = 0, e_peak = 0, e_err = 0;
    if (idx < CH) begin e_cnt = m_cnt[s][idx]; e_peak = m_peak[s][idx]; end
    for (int c = 0; c < CH; c++) e_err += m_err[s][c] << c;
    check({tag, " count_out"}, 32'(cnt_o), e_cnt);
    check({tag, " peak_out"},  32'(peak_o), e_peak);
    check({tag, " total_out"}, 32'(total_o), m_total[s]);
    check({tag, " err"},       32'(err_o), e_err);
    check({tag, " alarm"},     32'(alarm_o), m_alarm[s]);
  endtask

  // Model advances on every clock edge or reset assertion.
  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else model_step();
    end
  end

  // Every falling edge: both monitors against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (started) begin
        compare_dut(0, "wrap", bw.count_out, bw.peak_out, bw.total_out, bw.err, bw.alarm);
        compare_dut(1, "sat",  bs.count_out, bs.peak_out, bs.total_out, bs.err, bs.alarm);
      end
    end
  end

  task automatic step(input logic [3:0] ch, input logic [3:0] oo, input logic cp, input logic ce);
    change = ch; on_off = oo; clr_peak = cp; clr_err = ce;
    @(posedge clk); #2;
    change = '0; on_off = '0; clr_peak = 1'b0; clr_err = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step(4'h0, 4'h0, 1'b0, 1'b0);
  endtask

  initial begin
    model_reset();
    rst = 1'b1; change = '0; on_off = '0; clr_peak = 1'b0; clr_err = 1'b0;
    thresh = 10'd10; rd_sel = 4'd0;
    repeat (2) @(posedge clk);
    #2;
    started = 1'b1;
    check("reset total", 32'(bw.total_out), 0);
    check("reset alarm", 32'(bs.alarm), 0);
    rst = 1'b0;

    // Run ch0/ch1 up to full scale, then over the top.
    repeat (255) step(4'b0011, 4'b0011, 1'b0, 1'b0);
    check("wrap ch0 at max", 32'(bw.count_out), 255);
    check("sat ch0 at max", 32'(bs.count_out), 255);
    step(4'b0011, 4'b0011, 1'b0, 1'b0);
    check("wrap ch0 rolled over", 32'(bw.count_out), 0);
    check("wrap err stays clear", 32'(bw.err), 0);
    check("sat ch0 clamped", 32'(bs.count_out), 255);
    check("sat err both", 32'(bs.err), 3);
    rd_sel = 4'd1; #1;
    check("sat ch1 clamped", 32'(bs.count_out), 255);
    rd_sel = 4'd0;
    step(4'b0001, 4'b0000, 1'b0, 1'b0);
    check("wrap ch0 rolled under", 32'(bw.count_out), 255);
    check("sat ch0 dec from max", 32'(bs.count_out), 254);
    step(4'b0010, 4'b0010, 1'b0, 1'b1);
    check("sat clr_err vs new err", 32'(bs.err), 2);
    step(4'b0000, 4'b0000, 1'b0, 1'b1);
    check("sat clr_err alone", 32'(bs.err), 0);

    // Asynchronous reset in the middle of a cycle while all channels count.
    repeat (3) step(4'hf, 4'hf, 1'b0, 1'b0);
    change = 4'hf; on_off = 4'hf;
    #1 rst = 1'b1;
    #1;
    check("async rst wrap total", 32'(bw.total_out), 0);
    check("async rst wrap count", 32'(bw.count_out), 0);
    check("async rst wrap peak", 32'(bw.peak_out), 0);
    check("async rst wrap alarm", 32'(bw.alarm), 0);
    check("async rst sat err", 32'(bs.err), 0);
    check("async rst sat count", 32'(bs.count_out), 0);
    @(posedge clk); #2;
    rst = 1'b0; change = '0; on_off = '0;
    step(4'b0001, 4'b0001, 1'b0, 1'b0);
    check("first inc after reset", 32'(bw.count_out), 1);
    step(4'b0001, 4'b0000, 1'b0, 1'b0);

    // Alarm with threshold 10 and hysteresis 2.
    repeat (3) step(4'hf, 4'hf, 1'b0, 1'b0);
    idle(2);
    check("total 12", 32'(bw.total_out), 12);
    check("alarm at 12", 32'(bw.alarm), 1);
    step(4'b0111, 4'b0000, 1'b0, 1'b0);
    idle(2);
    check("total 9", 32'(bs.total_out), 9);
    check("alarm held at 9", 32'(bs.alarm), 1);
    step(4'b0011, 4'b0000, 1'b0, 1'b0);
    idle(1);
    check("total 7", 32'(bw.total_out), 7);
    check("alarm not yet released", 32'(bw.alarm), 1);
    idle(1);
    check("alarm released", 32'(bw.alarm), 0);

    // Peak tracking on ch2.
    repeat (3) step(4'b0100, 4'b0100, 1'b0, 1'b0);
    repeat (3) step(4'b0100, 4'b0000, 1'b0, 1'b0);
    rd_sel = 4'd2; #1;
    check("ch2 peak 5", 32'(bw.peak_out), 5);
    check("ch2 count 2", 32'(bw.count_out), 2);
    step(4'b0000, 4'b0000, 1'b1, 1'b0);
    check("ch2 peak cleared", 32'(bs.peak_out), 2);
    rd_sel = 4'd5; #1;
    check("rd_sel 5 count", 32'(bw.count_out), 0);
    check("rd_sel 5 peak", 32'(bs.peak_out), 0);

    // Threshold below hysteresis: release only at an empty fleet.
    thresh = 10'd1; rd_sel = 4'd3;
    idle(2);
    step(4'hf, 4'h0, 1'b0, 1'b0);
    step(4'b1100, 4'b0000, 1'b0, 1'b0);
    idle(2);
    check("total 1", 32'(bw.total_out), 1);
    check("alarm at 1 low thresh", 32'(bw.alarm), 1);
    step(4'b1000, 4'b0000, 1'b0, 1'b0);
    idle(2);
    check("total 0", 32'(bs.total_out), 0);
    check("alarm released at 0", 32'(bs.alarm), 0);

    idle(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
